// File: rtl/pe_pkg.sv
// Shared types and fixed-point helpers for the parametrised processing element.
// Helpers work on a wide signed carrier and take the target width as an argument,
// so they can serve any DATA_WIDTH up to MAX_WIDTH.
package pe_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  typedef logic signed [2*MAX_WIDTH-1:0] wide_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WS_RUN   = 2'd1,
    OS_ACC   = 2'd2,
    OS_DRAIN = 2'd3
  } pe_state_e;

  typedef struct packed {
    wide_t value;
    logic  sat;
  } sat_res_t;

  // Clip x into the signed range of 'width' bits; sat reports whether it clipped.
  function automatic sat_res_t clamp(input wide_t x, input int unsigned width);
    wide_t    hi;
    wide_t    lo;
    sat_res_t r;
    hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (width - 1));
    r.sat = 1'b1;
    if (x > hi) begin
      r.value = hi;
    end else if (x < lo) begin
      r.value = lo;
    end else begin
      r.value = x;
      r.sat   = 1'b0;
    end
    return r;
  endfunction

  function automatic sat_res_t sat_add(input wide_t a, input wide_t b,
                                       input int unsigned width);
    return clamp(a + b, width);
  endfunction

  // Round half up by adding 2^(frac-1), then arithmetic shift and clip.
  function automatic sat_res_t round_shift_sat(input wide_t prod, input int unsigned frac,
                                               input int unsigned width);
    wide_t rounded;
    rounded = (prod + (wide_t'(1) <<< (frac - 1))) >>> frac;
    return clamp(rounded, width);
  endfunction

endpackage

// File: rtl/pe_param_fxp_mac_sat.sv
// Combinational saturating fixed-point multiply-accumulate.
//   a, b    : multiplicands (signed Q format, FRAC_BITS fractional bits)
//   addend  : value added to the rounded, saturated product
//   result  : add(mul(a, b), addend), saturated to DATA_WIDTH
//   sat     : either the product or the sum clipped
module fxp_mac_sat
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] addend,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  sat
);

  wide_t    a_x;
  wide_t    b_x;
  wide_t    c_x;
  wide_t    prod;
  sat_res_t mul_r;
  sat_res_t add_r;
  logic     unused_hi;

  always_comb begin
    a_x    = wide_t'(signed'(a));
    b_x    = wide_t'(signed'(b));
    c_x    = wide_t'(signed'(addend));
    prod   = a_x * b_x;
    mul_r  = round_shift_sat(prod, FRAC_BITS, DATA_WIDTH);
    add_r  = sat_add(mul_r.value, c_x, DATA_WIDTH);
    result = add_r.value[DATA_WIDTH-1:0];
    sat    = mul_r.sat | add_r.sat;
  end

  // Upper carrier bits are a pure sign extension after clamping.
  assign unused_hi = ^add_r.value[2*MAX_WIDTH-1:DATA_WIDTH];

endmodule

// File: rtl/pe_param.sv
// Parametrised systolic-array processing element.
// Modes (frozen on leaving IDLE): weight-stationary with double-buffered weight,
// or output-stationary with a local accumulator drained down the psum chain.
//   clk, rst (async, active-high), pe_enabled (low = synchronous clear)
//   pe_mode_os      : 0 = WS, 1 = OS, sampled in IDLE
//   pe_sat_clr      : clears the sticky pe_sat_flag
//   pe_psum_*       : north -> south partial sum
//   pe_weight_*     : north -> south weight, pe_accept_w_* its strobe
//   pe_input_*      : west -> east activation, pe_valid_* its strobe
//   pe_switch_*     : WS weight-swap strobe
//   pe_drain_*      : OS drain strobe
//   pe_sat_flag     : sticky saturation indicator
module pe_param
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pe_enabled,
  input  logic                  pe_mode_os,
  input  logic                  pe_sat_clr,
  input  logic [DATA_WIDTH-1:0] pe_psum_in,
  output logic [DATA_WIDTH-1:0] pe_psum_out,
  input  logic [DATA_WIDTH-1:0] pe_weight_in,
  output logic [DATA_WIDTH-1:0] pe_weight_out,
  input  logic                  pe_accept_w_in,
  output logic                  pe_accept_w_out,
  input  logic [DATA_WIDTH-1:0] pe_input_in,
  output logic [DATA_WIDTH-1:0] pe_input_out,
  input  logic                  pe_valid_in,
  output logic                  pe_valid_out,
  input  logic                  pe_switch_in,
  output logic                  pe_switch_out,
  input  logic                  pe_drain_in,
  output logic                  pe_drain_out,
  output logic                  pe_sat_flag
);

  pe_state_e state_q;
  pe_state_e state_d;

  logic [DATA_WIDTH-1:0] w_inactive;
  logic [DATA_WIDTH-1:0] w_active;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] w_inactive_d;
  logic [DATA_WIDTH-1:0] w_active_d;
  logic [DATA_WIDTH-1:0] acc_d;
  logic [DATA_WIDTH-1:0] psum_d;
  logic [DATA_WIDTH-1:0] weight_d;
  logic [DATA_WIDTH-1:0] input_d;
  logic                  valid_d;
  logic                  switch_d;
  logic                  accept_d;
  logic                  drain_d;
  logic                  sat_d;

  logic [DATA_WIDTH-1:0] w_eff;
  logic [DATA_WIDTH-1:0] mac_b;
  logic [DATA_WIDTH-1:0] mac_c;
  logic [DATA_WIDTH-1:0] mac_result;
  logic                  mac_sat;
  logic                  mac_use;
  logic                  os_mode;

  // Shared MAC operand mux: WS uses the effective weight and psum_in; OS uses the
  // incoming weight and the accumulator (zero during a drain, so a MAC there
  // lands in the cleared accumulator).
  always_comb begin
    w_eff   = pe_switch_in ? w_inactive : w_active;
    os_mode = (state_q == OS_ACC) || (state_q == OS_DRAIN);
    mac_b   = os_mode ? pe_weight_in : w_eff;
    case (state_q)
      WS_RUN:  mac_c = pe_psum_in;
      OS_ACC:  mac_c = acc;
      default: mac_c = '0;
    endcase
    mac_use = pe_valid_in && ((state_q == WS_RUN) || (os_mode && pe_accept_w_in));
  end

  fxp_mac_sat #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_mac (
    .a     (pe_input_in),
    .b     (mac_b),
    .addend(mac_c),
    .result(mac_result),
    .sat   (mac_sat)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!pe_enabled) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     state_d = pe_mode_os ? OS_ACC : WS_RUN;
        WS_RUN:   state_d = WS_RUN;
        OS_ACC:   state_d = pe_drain_in ? OS_DRAIN : OS_ACC;
        OS_DRAIN: state_d = pe_drain_in ? OS_DRAIN : OS_ACC;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Output / datapath next-value logic
  always_comb begin
    w_inactive_d = w_inactive;
    w_active_d   = w_active;
    acc_d        = acc;
    psum_d       = pe_psum_out;
    weight_d     = pe_weight_out;
    input_d      = pe_input_out;
    valid_d      = pe_valid_in;
    switch_d     = pe_switch_in;
    accept_d     = pe_accept_w_in;
    drain_d      = pe_drain_in;
    // A clear and a simultaneous saturation leave the flag set.
    sat_d        = (pe_sat_flag & ~pe_sat_clr) | (mac_use & mac_sat);

    if (!pe_enabled) begin
      w_inactive_d = '0;
      w_active_d   = '0;
      acc_d        = '0;
      psum_d       = '0;
      weight_d     = '0;
      input_d      = '0;
      valid_d      = 1'b0;
      switch_d     = 1'b0;
      accept_d     = 1'b0;
      drain_d      = 1'b0;
      sat_d        = 1'b0;
    end else begin
      case (state_q)
        WS_RUN: begin
          weight_d = pe_accept_w_in ? pe_weight_in : '0;
          if (pe_accept_w_in) begin
            w_inactive_d = pe_weight_in;
          end
          if (pe_switch_in) begin
            w_active_d = w_inactive;
          end
          psum_d = pe_valid_in ? mac_result : '0;
          if (pe_valid_in) begin
            input_d = pe_input_in;
          end
        end
        OS_ACC, OS_DRAIN: begin
          weight_d = pe_accept_w_in ? pe_weight_in : '0;
          if (pe_valid_in) begin
            input_d = pe_input_in;
          end
          psum_d = (state_q == OS_DRAIN) ? acc : pe_psum_in;
          acc_d  = (state_q == OS_DRAIN) ? '0 : acc;
          if (pe_valid_in && pe_accept_w_in) begin
            acc_d = mac_result;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_inactive      <= '0;
      w_active        <= '0;
      acc             <= '0;
      pe_psum_out     <= '0;
      pe_weight_out   <= '0;
      pe_input_out    <= '0;
      pe_valid_out    <= 1'b0;
      pe_switch_out   <= 1'b0;
      pe_accept_w_out <= 1'b0;
      pe_drain_out    <= 1'b0;
      pe_sat_flag     <= 1'b0;
    end else begin
      w_inactive      <= w_inactive_d;
      w_active        <= w_active_d;
      acc             <= acc_d;
      pe_psum_out     <= psum_d;
      pe_weight_out   <= weight_d;
      pe_input_out    <= input_d;
      pe_valid_out    <= valid_d;
      pe_switch_out   <= switch_d;
      pe_accept_w_out <= accept_d;
      pe_drain_out    <= drain_d;
      pe_sat_flag     <= sat_d;
    end
  end

endmodule

// File: tb/tb_pe_param.sv
// Self-checking bench for pe_param (DATA_WIDTH=16, FRAC_BITS=8): directed
// scenarios with literal expectations plus a randomized run against a
// cycle-level arithmetic model.
module tb_pe_param;

  localparam int unsigned DW = 16;
  localparam int unsigned FB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          mode_os;
  logic          sat_clr;
  logic [DW-1:0] psum_in;
  logic [DW-1:0] weight_in;
  logic [DW-1:0] input_in;
  logic          accept_w_in;
  logic          valid_in;
  logic          switch_in;
  logic          drain_in;
  logic [DW-1:0] psum_out;
  logic [DW-1:0] weight_out;
  logic [DW-1:0] input_out;
  logic          accept_w_out;
  logic          valid_out;
  logic          switch_out;
  logic          drain_out;
  logic          sat_flag;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit            m_run;
  bit            m_os;
  bit            m_drain;
  bit            m_hit;
  int            m_inact;
  int            m_act;
  int            m_acc;
  logic [DW-1:0] e_psum;
  logic [DW-1:0] e_weight;
  logic [DW-1:0] e_input;
  logic [3:0]    e_strb;
  logic          e_sat;

  always #5 clk = ~clk;

  pe_param #(
    .DATA_WIDTH(DW),
    .FRAC_BITS (FB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pe_enabled     (en),
    .pe_mode_os     (mode_os),
    .pe_sat_clr     (sat_clr),
    .pe_psum_in     (psum_in),
    .pe_psum_out    (psum_out),
    .pe_weight_in   (weight_in),
    .pe_weight_out  (weight_out),
    .pe_accept_w_in (accept_w_in),
    .pe_accept_w_out(accept_w_out),
    .pe_input_in    (input_in),
    .pe_input_out   (input_out),
    .pe_valid_in    (valid_in),
    .pe_valid_out   (valid_out),
    .pe_switch_in   (switch_in),
    .pe_switch_out  (switch_out),
    .pe_drain_in    (drain_in),
    .pe_drain_out   (drain_out),
    .pe_sat_flag    (sat_flag)
  );

  function automatic int s16(input logic [DW-1:0] x);
    return int'(signed'(x));
  endfunction

  function automatic longint clip(input longint v);
    if (v > 64'sd32767) begin
      m_hit = 1'b1;
      return 64'sd32767;
    end
    if (v < -64'sd32768) begin
      m_hit = 1'b1;
      return -64'sd32768;
    end
    return v;
  endfunction

  // Real value a*b/256, rounded half up, then clipped.
  function automatic int fmul(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return int'(clip((p + 64'sd128) >>> FB));
  endfunction

  function automatic int fadd(input int a, input int b);
    return int'(clip(longint'(a) + longint'(b)));
  endfunction

  task automatic reset_model();
    m_run    = 1'b0;
    m_os     = 1'b0;
    m_drain  = 1'b0;
    m_inact  = 0;
    m_act    = 0;
    m_acc    = 0;
    e_psum   = '0;
    e_weight = '0;
    e_input  = '0;
    e_strb   = '0;
    e_sat    = 1'b0;
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    int weff;
    int base;
    m_hit = 1'b0;
    if (rst || !en) begin
      reset_model();
      return;
    end
    e_strb = {valid_in, switch_in, accept_w_in, drain_in};
    if (!m_run) begin
      m_run   = 1'b1;
      m_os    = mode_os;
      m_drain = 1'b0;
    end else if (!m_os) begin
      weff = switch_in ? m_inact : m_act;
      if (valid_in) begin
        e_psum  = 16'(fadd(fmul(s16(input_in), weff), s16(psum_in)));
        e_input = input_in;
      end else begin
        e_psum = '0;
      end
      if (switch_in) m_act = m_inact;
      if (accept_w_in) m_inact = s16(weight_in);
      e_weight = accept_w_in ? weight_in : '0;
    end else begin
      base   = m_drain ? 0 : m_acc;
      e_psum = m_drain ? 16'(m_acc) : psum_in;
      m_acc  = base;
      if (valid_in && accept_w_in) m_acc = fadd(base, fmul(s16(input_in), s16(weight_in)));
      if (valid_in) e_input = input_in;
      e_weight = accept_w_in ? weight_in : '0;
      m_drain  = drain_in;
    end
    e_sat = (e_sat && !sat_clr) || m_hit;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [DW-1:0] x, input logic [DW-1:0] ps,
                        input logic a, input logic [DW-1:0] w, input logic sw,
                        input logic dr);
    valid_in    = v;
    input_in    = x;
    psum_in     = ps;
    accept_w_in = a;
    weight_in   = w;
    switch_in   = sw;
    drain_in    = dr;
    sat_clr     = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd16();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom);
      1:       return 16'($urandom_range(0, 1023)) - 16'd512;
      2:       return 16'h7FFF - 16'($urandom_range(0, 15));
      default: return 16'h8000 + 16'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    mode_os = 1'b0;
    set_in(0, '0, '0, 0, '0, 0, 0);
    tick();
    checks++; if (psum_out !== '0) begin failures++; $display("FAIL reset psum: got %h expected 0000", psum_out); end
    checks++; if (weight_out !== '0) begin failures++; $display("FAIL reset weight: got %h expected 0000", weight_out); end
    checks++; if (input_out !== '0) begin failures++; $display("FAIL reset input: got %h expected 0000", input_out); end
    checks++; if ({valid_out, switch_out, accept_w_out, drain_out} !== 4'b0) begin
      failures++; $display("FAIL reset strobes: got %b expected 0000", {valid_out, switch_out, accept_w_out, drain_out}); end
    checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL reset sat: got %b expected 0", sat_flag); end
    rst = 1'b0;
  endtask

  task automatic test_ws_basic();
    en = 1'b1;
    mode_os = 1'b0;
    set_in(0, '0, '0, 0, '0, 0, 0); tick();
    set_in(0, '0, '0, 1, 16'h0200, 0, 0); tick();
    checks++; if (weight_out !== 16'h0200) begin failures++; $display("FAIL ws weight fwd: got %h expected 0200", weight_out); end
    checks++; if (accept_w_out !== 1'b1) begin failures++; $display("FAIL ws accept fwd: got %b expected 1", accept_w_out); end
    set_in(0, '0, '0, 0, '0, 1, 0); tick();
    checks++; if (switch_out !== 1'b1) begin failures++; $display("FAIL ws switch fwd: got %b expected 1", switch_out); end
    checks++; if (weight_out !== 16'h0000) begin failures++; $display("FAIL ws weight idle: got %h expected 0000", weight_out); end
    set_in(1, 16'h0180, 16'h0100, 0, '0, 0, 0); tick();
    checks++; if (psum_out !== 16'h0400) begin failures++; $display("FAIL ws basic psum: got %h expected 0400", psum_out); end
    checks++; if (input_out !== 16'h0180) begin failures++; $display("FAIL ws input fwd: got %h expected 0180", input_out); end
    checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL ws basic sat: got %b expected 0", sat_flag); end
    set_in(0, 16'h1234, 16'h5555, 0, '0, 0, 0); tick();
    checks++; if (psum_out !== 16'h0000) begin failures++; $display("FAIL ws novalid psum: got %h expected 0000", psum_out); end
    checks++; if (input_out !== 16'h0180) begin failures++; $display("FAIL ws input hold: got %h expected 0180", input_out); end
  endtask

  task automatic test_swap_bypass();
    set_in(0, '0, '0, 1, 16'h0100, 0, 0); tick();
    set_in(0, '0, '0, 0, '0, 1, 0); tick();
    set_in(0, '0, '0, 1, 16'h0300, 0, 0); tick();
    set_in(1, 16'h0100, '0, 0, '0, 1, 0); tick();
    checks++; if (psum_out !== 16'h0300) begin failures++; $display("FAIL swap bypass: got %h expected 0300", psum_out); end
    set_in(1, 16'h0200, '0, 0, '0, 0, 0); tick();
    checks++; if (psum_out !== 16'h0600) begin failures++; $display("FAIL after swap: got %h expected 0600", psum_out); end
    set_in(0, '0, '0, 1, 16'h0500, 0, 0); tick();
    set_in(0, '0, '0, 1, 16'h0400, 1, 0); tick();
    set_in(1, 16'h0100, '0, 0, '0, 0, 0); tick();
    checks++; if (psum_out !== 16'h0500) begin failures++; $display("FAIL swap+load active: got %h expected 0500", psum_out); end
    set_in(1, 16'h0100, '0, 0, '0, 1, 0); tick();
    checks++; if (psum_out !== 16'h0400) begin failures++; $display("FAIL swap+load inactive: got %h expected 0400", psum_out); end
  endtask

  task automatic test_saturation();
    set_in(0, '0, '0, 1, 16'h7FFF, 0, 0); tick();
    set_in(0, '0, '0, 0, '0, 1, 0); tick();
    set_in(1, 16'h7FFF, 16'h7000, 0, '0, 0, 0); tick();
    checks++; if (psum_out !== 16'h7FFF) begin failures++; $display("FAIL sat pos psum: got %h expected 7fff", psum_out); end
    checks++; if (sat_flag !== 1'b1) begin failures++; $display("FAIL sat pos flag: got %b expected 1", sat_flag); end
    set_in(0, '0, '0, 0, '0, 0, 0); sat_clr = 1'b1; tick();
    checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL sat clear: got %b expected 0", sat_flag); end
    set_in(1, 16'h0100, 16'h0001, 0, '0, 0, 0); tick();
    checks++; if (psum_out !== 16'h7FFF || sat_flag !== 1'b1) begin
      failures++; $display("FAIL sat add-only: got %h/%b expected 7fff/1", psum_out, sat_flag); end
    set_in(0, '0, '0, 0, '0, 0, 0); sat_clr = 1'b1; tick();
    set_in(1, 16'h8000, '0, 0, '0, 0, 0); tick();
    checks++; if (psum_out !== 16'h8000) begin failures++; $display("FAIL sat neg psum: got %h expected 8000", psum_out); end
    checks++; if (sat_flag !== 1'b1) begin failures++; $display("FAIL sat neg flag: got %b expected 1", sat_flag); end
    set_in(0, '0, '0, 0, '0, 0, 0); sat_clr = 1'b1; tick();
    set_in(1, 16'h8000, '0, 0, '0, 0, 0); sat_clr = 1'b1; tick();
    checks++; if (sat_flag !== 1'b1) begin failures++; $display("FAIL sat clr+hit: got %b expected 1", sat_flag); end
  endtask

  task automatic test_rounding();
    set_in(0, '0, '0, 0, '0, 0, 0); sat_clr = 1'b1; tick();
    set_in(0, '0, '0, 1, 16'h0001, 0, 0); tick();
    set_in(0, '0, '0, 0, '0, 1, 0); tick();
    set_in(1, 16'h0080, '0, 0, '0, 0, 0); tick();
    checks++; if (psum_out !== 16'h0001) begin failures++; $display("FAIL round half up: got %h expected 0001", psum_out); end
    set_in(1, 16'h007F, '0, 0, '0, 0, 0); tick();
    checks++; if (psum_out !== 16'h0000) begin failures++; $display("FAIL round below half: got %h expected 0000", psum_out); end
    set_in(1, 16'hFF80, '0, 0, '0, 0, 0); tick();
    checks++; if (psum_out !== 16'h0000) begin failures++; $display("FAIL round neg half: got %h expected 0000", psum_out); end
    set_in(1, 16'hFF7F, '0, 0, '0, 0, 0); tick();
    checks++; if (psum_out !== 16'hFFFF) begin failures++; $display("FAIL round neg below: got %h expected ffff", psum_out); end
    checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL round sat: got %b expected 0", sat_flag); end
    // Leave the flag set so the disable below has something to clear.
    set_in(1, 16'h7FFF, 16'h7FFF, 0, '0, 0, 0); tick();
  endtask

  task automatic test_os();
    logic [DW-1:0] ps;
    en = 1'b0;
    set_in(0, '0, '0, 0, '0, 0, 0); tick();
    checks++; if ({psum_out, weight_out, input_out} !== '0) begin
      failures++; $display("FAIL disable data: got %h %h %h expected zeros", psum_out, weight_out, input_out); end
    checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL disable sat: got %b expected 0", sat_flag); end
    en = 1'b1;
    mode_os = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      ps = 16'($urandom);
      set_in(1, 16'h0100, ps, 1, 16'h0200, 0, 0); tick();
      checks++; if (psum_out !== ps) begin failures++; $display("FAIL os chain %0d: got %h expected %h", i, psum_out, ps); end
      checks++; if (input_out !== 16'h0100 || weight_out !== 16'h0200) begin
        failures++; $display("FAIL os fwd %0d: got %h/%h expected 0100/0200", i, input_out, weight_out); end
    end
    set_in(0, '0, 16'h1111, 0, '0, 0, 1); tick();
    checks++; if (psum_out !== 16'h1111 || drain_out !== 1'b1) begin
      failures++; $display("FAIL os drain strobe: got %h/%b expected 1111/1", psum_out, drain_out); end
    set_in(0, '0, 16'h2222, 0, '0, 0, 0); tick();
    checks++; if (psum_out !== 16'h0800) begin failures++; $display("FAIL os drain value: got %h expected 0800", psum_out); end
    set_in(0, '0, '0, 0, '0, 0, 1); tick();
    set_in(0, '0, 16'h3333, 0, '0, 0, 0); tick();
    checks++; if (psum_out !== 16'h0000) begin failures++; $display("FAIL os second drain: got %h expected 0000", psum_out); end
    set_in(1, 16'h0100, '0, 1, 16'h0300, 0, 0); tick();
    set_in(0, '0, '0, 0, '0, 0, 1); tick();
    set_in(1, 16'h0100, '0, 1, 16'h0200, 0, 1); tick();
    checks++; if (psum_out !== 16'h0300) begin failures++; $display("FAIL os b2b drain 1: got %h expected 0300", psum_out); end
    set_in(0, '0, '0, 0, '0, 0, 0); tick();
    checks++; if (psum_out !== 16'h0200) begin failures++; $display("FAIL os b2b drain 2: got %h expected 0200", psum_out); end
    set_in(0, '0, 16'h4444, 0, '0, 0, 0); tick();
    checks++; if (psum_out !== 16'h4444) begin failures++; $display("FAIL os back to chain: got %h expected 4444", psum_out); end
  endtask

  task automatic test_async_reset();
    set_in(1, 16'h0100, '0, 1, 16'h0500, 0, 0); tick();
    checks++; if (weight_out !== 16'h0500) begin failures++; $display("FAIL areset pre weight: got %h expected 0500", weight_out); end
    #2;
    rst = 1'b1;
    reset_model();
    #1;
    checks++; if ({psum_out, weight_out, input_out} !== '0) begin
      failures++; $display("FAIL areset data: got %h %h %h expected zeros", psum_out, weight_out, input_out); end
    checks++; if ({valid_out, switch_out, accept_w_out, drain_out, sat_flag} !== 5'b0) begin
      failures++; $display("FAIL areset strobes: got %b expected 00000", {valid_out, switch_out, accept_w_out, drain_out, sat_flag}); end
    rst = 1'b0;
    en = 1'b1;
    mode_os = 1'b1;
    set_in(0, '0, '0, 0, '0, 0, 0); tick();
    set_in(0, '0, '0, 0, '0, 0, 1); tick();
    set_in(0, '0, 16'h5555, 0, '0, 0, 0); tick();
    checks++; if (psum_out !== 16'h0000) begin failures++; $display("FAIL areset drain: got %h expected 0000", psum_out); end
  endtask

  task automatic test_random();
    rst = 1'b1;
    set_in(0, '0, '0, 0, '0, 0, 0); tick();
    rst = 1'b0;
    for (int i = 0; i < 800; i++) begin
      en          = ($urandom_range(0, 39) != 0);
      mode_os     = 1'($urandom_range(0, 1));
      valid_in    = ($urandom_range(0, 3) != 0);
      accept_w_in = ($urandom_range(0, 2) != 0);
      switch_in   = ($urandom_range(0, 4) == 0);
      drain_in    = ($urandom_range(0, 5) == 0);
      sat_clr     = ($urandom_range(0, 7) == 0);
      input_in    = rnd16();
      weight_in   = rnd16();
      psum_in     = rnd16();
      tick();
      checks++; if (psum_out !== e_psum) begin failures++; $display("FAIL rand psum @%0d: got %h expected %h", i, psum_out, e_psum); end
      checks++; if (weight_out !== e_weight) begin failures++; $display("FAIL rand weight @%0d: got %h expected %h", i, weight_out, e_weight); end
      checks++; if (input_out !== e_input) begin failures++; $display("FAIL rand input @%0d: got %h expected %h", i, input_out, e_input); end
      checks++; if ({valid_out, switch_out, accept_w_out, drain_out} !== e_strb) begin
        failures++; $display("FAIL rand strobes @%0d: got %b expected %b", i, {valid_out, switch_out, accept_w_out, drain_out}, e_strb); end
      checks++; if (sat_flag !== e_sat) begin failures++; $display("FAIL rand sat @%0d: got %b expected %b", i, sat_flag, e_sat); end
    end
  endtask

  initial begin
    reset_model();
    test_reset();
    test_ws_basic();
    test_swap_bypass();
    test_saturation();
    test_rounding();
    test_os();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
